cp0_irq_ctrl: RTL and testbench

Coprocessor-0 interrupt/exception controller on the CPU side of the peripheral IRQ lines.
- Collects device interrupt requests (timer IRQ and others) on HWInt.
- Masks them with software-programmed status bits and raises a single request to the pipeline.
- On a taken request, captures EPC and cause; supports mtc0/mfc0 register access and eret.
- Sits in the MEM stage beside the system bridge.

---
 rtl/cp0_irq_ctrl_pkg.sv | 25 ++
 rtl/cp0_irq_ctrl.sv | 124 ++++++++++++
 tb/tb_cp0_irq_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/cp0_irq_ctrl_pkg.sv
// Shared CP0 definitions: register numbers, field positions and exception codes.
package cp0_irq_ctrl_pkg;

   localparam logic [4:0] CP0_SR    = 5'd12;
   localparam logic [4:0] CP0_CAUSE = 5'd13;
   localparam logic [4:0] CP0_EPC   = 5'd14;
   localparam logic [4:0] CP0_PRID  = 5'd15;

   localparam int unsigned IM_HI  = 15;
   localparam int unsigned IM_LO  = 10;
   localparam int unsigned EXL    = 1;
   localparam int unsigned IE     = 0;
   localparam int unsigned BD_BIT = 31;
   localparam int unsigned IP_HI  = 15;
   localparam int unsigned IP_LO  = 10;
   localparam int unsigned EXC_HI = 6;
   localparam int unsigned EXC_LO = 2;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

endpackage

// File: rtl/cp0_irq_ctrl.sv
// CP0 interrupt/exception controller: SR/Cause/EPC/PRId registers, request
// generation toward the pipeline, trap capture and eret handling.
module cp0_irq_ctrl
   import cp0_irq_ctrl_pkg::*;
#(
   parameter logic [31:0] PRID = 32'h0000_2018
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  A1,
   input  logic [4:0]  A2,
   input  logic [31:0] DIn,
   input  logic        We,
   input  logic [31:0] PC,
   input  logic        BD,
   input  logic [4:0]  ExcCode,
   input  logic [5:0]  HWInt,
   input  logic        EXLClr,
   output logic        Req,
   output logic [31:0] EPC,
   output logic [31:0] DOut
);

   logic [5:0]  im_q, im_d;
   logic        exl_q, exl_d;
   logic        ie_q, ie_d;
   logic        bd_q, bd_d;
   logic [5:0]  ip_q, ip_d;
   logic [4:0]  exc_q, exc_d;
   logic [29:0] epc_q, epc_d;

   logic        int_req_c;
   logic        exc_req_c;
   logic [29:0] trap_epc_c;
   logic [31:0] sr_c;
   logic [31:0] cause_c;
   logic        unused_c;

   // Requests are masked entirely while a handler runs (EXL=1).
   assign int_req_c  = ie_q & ~exl_q & (|(HWInt & im_q));
   assign exc_req_c  = (ExcCode != 5'd0) & ~exl_q;
   assign Req        = int_req_c | exc_req_c;
   assign trap_epc_c = BD ? (PC[31:2] - 30'd1) : PC[31:2];
   assign unused_c   = ^PC[1:0];

   always_comb begin
      sr_c                = '0;
      sr_c[IM_HI:IM_LO]   = im_q;
      sr_c[EXL]           = exl_q;
      sr_c[IE]            = ie_q;
      cause_c             = '0;
      cause_c[BD_BIT]     = bd_q;
      cause_c[IP_HI:IP_LO]   = ip_q;
      cause_c[EXC_HI:EXC_LO] = exc_q;
   end

   assign EPC = {epc_q, 2'b00};

   // mfc0 read port reflects pre-edge state; no write bypass.
   always_comb begin
      DOut = '0;
      case (A1)
         CP0_SR:    DOut = sr_c;
         CP0_CAUSE: DOut = cause_c;
         CP0_EPC:   DOut = {epc_q, 2'b00};
         CP0_PRID:  DOut = PRID;
         default:   DOut = '0;
      endcase
   end

   // Trap capture outranks eret, which outranks mtc0.
   always_comb begin
      im_d  = im_q;
      exl_d = exl_q;
      ie_d  = ie_q;
      bd_d  = bd_q;
      ip_d  = HWInt;
      exc_d = exc_q;
      epc_d = epc_q;
      if (Req) begin
         exl_d = 1'b1;
         bd_d  = BD;
         exc_d = int_req_c ? EXC_INT : ExcCode;
         epc_d = trap_epc_c;
      end else if (EXLClr) begin
         exl_d = 1'b0;
         if (We && (A2 == CP0_SR)) begin
            im_d = DIn[IM_HI:IM_LO];
            ie_d = DIn[IE];
         end
      end else if (We) begin
         case (A2)
            CP0_SR: begin
               im_d  = DIn[IM_HI:IM_LO];
               exl_d = DIn[EXL];
               ie_d  = DIn[IE];
            end
            CP0_EPC: epc_d = DIn[31:2];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         im_q  <= '0;
         exl_q <= 1'b0;
         ie_q  <= 1'b0;
         bd_q  <= 1'b0;
         ip_q  <= '0;
         exc_q <= '0;
         epc_q <= '0;
      end else begin
         im_q  <= im_d;
         exl_q <= exl_d;
         ie_q  <= ie_d;
         bd_q  <= bd_d;
         ip_q  <= ip_d;
         exc_q <= exc_d;
         epc_q <= epc_d;
      end
   end

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Self-checking bench for cp0_irq_ctrl: expectations are queued as stimulus is
// driven and checked against Req/DOut/EPC at the following falling edge.
module tb_cp0_irq_ctrl;

   localparam int unsigned SEL_REQ  = 0;
   localparam int unsigned SEL_DOUT = 1;
   localparam int unsigned SEL_EPC  = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  a1, a2, exc_code;
   logic [31:0] din, pc;
   logic        we, bd, exl_clr;
   logic [5:0]  hw_int;
   logic        req;
   logic [31:0] epc, dout;

   typedef struct {
      string       tag;
      int unsigned sel;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   cp0_irq_ctrl dut (
      .clk    (clk),
      .reset  (reset),
      .A1     (a1),
      .A2     (a2),
      .DIn    (din),
      .We     (we),
      .PC     (pc),
      .BD     (bd),
      .ExcCode(exc_code),
      .HWInt  (hw_int),
      .EXLClr (exl_clr),
      .Req    (req),
      .EPC    (epc),
      .DOut   (dout)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic exp_out(input string tag, input int unsigned sel, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.val = val;
      sb.push_back(e);
   endtask

   // Check queued expectations mid-cycle, then advance past the next edge.
   task automatic step();
      exp_t        e;
      logic [31:0] obs;
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.sel)
            SEL_REQ:  obs = {31'd0, req};
            SEL_DOUT: obs = dout;
            default:  obs = epc;
         endcase
         check_val(e.tag, obs, e.val);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic mtc0(input logic [4:0] reg_n, input logic [31:0] data);
      we = 1'b1;
      a2 = reg_n;
      din = data;
      step();
      we = 1'b0;
   endtask

   initial begin
      reset = 1'b1; a1 = '0; a2 = '0; din = '0; we = 1'b0; pc = '0; bd = 1'b0;
      exc_code = '0; hw_int = '0; exl_clr = 1'b0;
      step();
      reset = 1'b0;

      // Reset state
      a1 = 5'd12; exp_out("rst_sr", SEL_DOUT, 32'h0); exp_out("rst_req", SEL_REQ, 32'h0); step();
      a1 = 5'd13; exp_out("rst_cause", SEL_DOUT, 32'h0); step();
      a1 = 5'd14; exp_out("rst_epc_rd", SEL_DOUT, 32'h0); exp_out("rst_epc", SEL_EPC, 32'h0); step();

      // Timer interrupt taken
      a1 = 5'd12; exp_out("sr_no_bypass", SEL_DOUT, 32'h0); mtc0(5'd12, 32'h0000_0401);
      hw_int = 6'b000001; pc = 32'h0000_3010;
      exp_out("irq_req", SEL_REQ, 32'h1); exp_out("sr_written", SEL_DOUT, 32'h0000_0401); step();
      hw_int = '0; a1 = 5'd13;
      exp_out("irq_epc", SEL_EPC, 32'h0000_3010); exp_out("irq_cause", SEL_DOUT, 32'h0000_0400);
      exp_out("irq_exl_mask", SEL_REQ, 32'h0); step();
      a1 = 5'd12; exp_out("irq_sr", SEL_DOUT, 32'h0000_0403); step();

      // Masked line: visible in Cause.IP, no request
      mtc0(5'd12, 32'h0000_0401);
      hw_int = 6'b000010; exp_out("masked_req", SEL_REQ, 32'h0); step();
      hw_int = '0; a1 = 5'd13; exp_out("masked_ip", SEL_DOUT, 32'h0000_0800); step();

      // Overflow exception in a delay slot
      mtc0(5'd12, 32'h0000_0001);
      exc_code = 5'd12; bd = 1'b1; pc = 32'h0000_3020;
      exp_out("ov_req", SEL_REQ, 32'h1); step();
      exc_code = '0; bd = 1'b0;
      exp_out("ov_epc", SEL_EPC, 32'h0000_301C); exp_out("ov_cause", SEL_DOUT, 32'h8000_0030); step();

      // EXL masks, eret unmasks a held line
      mtc0(5'd12, 32'h0000_0403);
      hw_int = 6'b000001; exc_code = 5'd10; exp_out("exl_mask", SEL_REQ, 32'h0); step();
      exc_code = '0; exl_clr = 1'b1; exp_out("eret_cycle", SEL_REQ, 32'h0); step();
      exl_clr = 1'b0; pc = 32'h0000_4000; exc_code = 5'd10;
      we = 1'b1; a2 = 5'd14; din = 32'h1234_5678;
      exp_out("post_eret_req", SEL_REQ, 32'h1); step();
      we = 1'b0; hw_int = '0; exc_code = '0;
      exp_out("trap_beats_we", SEL_EPC, 32'h0000_4000); exp_out("int_outranks", SEL_DOUT, 32'h0000_0400);
      step();

      // EPC low bits forced to zero
      mtc0(5'd14, 32'h0000_3003);
      a1 = 5'd14; exp_out("epc_rd", SEL_DOUT, 32'h0000_3000); exp_out("epc_out", SEL_EPC, 32'h0000_3000); step();
      a1 = 5'd15; exp_out("prid", SEL_DOUT, 32'h0000_2018); step();
      a1 = 5'd7;  exp_out("unmapped", SEL_DOUT, 32'h0); step();

      // Reset mid-handler with a pending line
      hw_int = 6'b000001; reset = 1'b1; step();
      reset = 1'b0; a1 = 5'd13;
      exp_out("mid_rst_cause", SEL_DOUT, 32'h0); exp_out("mid_rst_epc", SEL_EPC, 32'h0);
      exp_out("mid_rst_req", SEL_REQ, 32'h0); step();
      a1 = 5'd12; exp_out("mid_rst_sr", SEL_DOUT, 32'h0); exp_out("mid_rst_req2", SEL_REQ, 32'h0); step();
      hw_int = '0;

      // EPC wrap for delay-slot PC=0
      mtc0(5'd12, 32'h0000_0001);
      exc_code = 5'd4; bd = 1'b1; pc = 32'h0; exp_out("wrap_req", SEL_REQ, 32'h1); step();
      exc_code = '0; bd = 1'b0; a1 = 5'd13;
      exp_out("wrap_epc", SEL_EPC, 32'hFFFF_FFFC); exp_out("wrap_cause", SEL_DOUT, 32'h8000_0010); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
